bht_predictor: RTL

//  Tagged, direct-mapped branch history table holding CTR_WIDTH-bit saturating counters.

---
 rtl/bht_pkg.sv | 49 ++++
 rtl/bht_ctr_next.sv | 38 +++
 rtl/bht_predictor.sv | 162 ++++++++++++++++
 3 files changed

// File: rtl/bht_pkg.sv
// ---------------------------------------------------------------------------
// bht_pkg
// Shared helpers for the branch history table:
//   - index/tag width helpers derived from PC width and table depth
//   - counter encoding helpers (weak taken, weak not-taken, saturation max)
//   - registered prediction record used by the guess port
// Counter encoding: 0 = strongly not-taken, 2^CTR_WIDTH-1 = strongly taken.
// ---------------------------------------------------------------------------
package bht_pkg;

   // Number of index bits for a power-of-two table depth.
   function automatic int idx_bits(input int entries);
      return (entries < 2) ? 1 : $clog2(entries);
   endfunction

   // Tag width: everything above the index, excluding the two byte-offset bits.
   function automatic int tag_bits(input int pc_width, input int entries);
      return pc_width - idx_bits(entries) - 2;
   endfunction

   // Saturation ceiling (strongly taken).
   function automatic int ctr_max(input int ctr_width);
      return (1 << ctr_width) - 1;
   endfunction

   // Allocation value for a taken outcome (weakly taken).
   function automatic int ctr_weak_t(input int ctr_width);
      return 1 << (ctr_width - 1);
   endfunction

   // Allocation value for a not-taken outcome (weakly not-taken).
   function automatic int ctr_weak_nt(input int ctr_width);
      return (1 << (ctr_width - 1)) - 1;
   endfunction

   // Default-configuration constants.
   localparam int BHT_CTR_WIDTH = 2;
   localparam int CTR_WEAK_T    = ctr_weak_t(BHT_CTR_WIDTH);
   localparam int CTR_WEAK_NT   = ctr_weak_nt(BHT_CTR_WIDTH);
   localparam int CTR_MAX       = ctr_max(BHT_CTR_WIDTH);

   // Registered guess result.
   typedef struct packed {
      logic valid;
      logic taken;
      logic hit;
   } bht_pred_t;

endpackage

// File: rtl/bht_ctr_next.sv
// ---------------------------------------------------------------------------
// bht_ctr_next
// Combinational next-counter computation for one table entry.
//   hit      in   1          entry is valid and its tag matches
//   ctr      in   CTR_WIDTH  current counter value (ignored on a miss)
//   taken    in   1          resolved branch direction
//   ctr_next out  CTR_WIDTH  saturating step on a hit, weak allocation on a miss
// ---------------------------------------------------------------------------
module bht_ctr_next
   import bht_pkg::*;
#(
   parameter int CTR_WIDTH = 2
) (
   input  logic                 hit,
   input  logic [CTR_WIDTH-1:0] ctr,
   input  logic                 taken,
   output logic [CTR_WIDTH-1:0] ctr_next
);

   localparam logic [CTR_WIDTH-1:0] MAX_VAL = CTR_WIDTH'(ctr_max(CTR_WIDTH));
   localparam logic [CTR_WIDTH-1:0] WEAK_T  = CTR_WIDTH'(ctr_weak_t(CTR_WIDTH));
   localparam logic [CTR_WIDTH-1:0] WEAK_NT = CTR_WIDTH'(ctr_weak_nt(CTR_WIDTH));
   localparam logic [CTR_WIDTH-1:0] ONE     = CTR_WIDTH'(1);

   always_comb begin
      // NOTE: default assignment first so every path drives ctr_next and no latch is inferred.
      ctr_next = ctr;
      if (!hit) begin
         ctr_next = taken ? WEAK_T : WEAK_NT;
      end else if (taken) begin
         // Saturation is tested before stepping so the counter never wraps.
         if (ctr != MAX_VAL) ctr_next = ctr + ONE;
      end else begin
         if (ctr != '0) ctr_next = ctr - ONE;
      end
   end

endmodule

// File: rtl/bht_predictor.sv
// ---------------------------------------------------------------------------
// bht_predictor
// Tagged, direct-mapped branch history table of saturating counters.
// One guess port (1-cycle registered result) and one update port that
// trains or allocates entries from resolved branch outcomes.
//
// Ports:
//   clk          in   1         rising-edge clock
//   rst          in   1         asynchronous active-high reset
//   guess_valid  in   1         a branch at guess_pc needs a prediction
//   guess_pc     in   PC_WIDTH  fetch PC of the branch
//   pred_valid   out  1         registered; guess result valid this cycle
//   pred_taken   out  1         registered; predicted direction
//   pred_hit     out  1         registered; tag matched a valid entry
//   check_valid  in   1         resolved branch outcome available
//   check_pc     in   PC_WIDTH  PC of the resolved branch
//   check_taken  in   1         actual direction
//
// Address split: idx = pc[IDX_BITS+1:2], tag = pc[PC_WIDTH-1:IDX_BITS+2].
//
// Build option BHT_BYPASS_EN: when defined, a same-cycle update to the
// guessed index is forwarded so the guess sees the entry exactly as it will
// be stored; when undefined the guess reads the table before the write.
// ---------------------------------------------------------------------------
module bht_predictor
   import bht_pkg::*;
#(
   parameter int PC_WIDTH  = 32,
   parameter int ENTRIES   = 32,
   parameter int CTR_WIDTH = 2
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                guess_valid,
   input  logic [PC_WIDTH-1:0] guess_pc,
   output logic                pred_valid,
   output logic                pred_taken,
   output logic                pred_hit,
   input  logic                check_valid,
   input  logic [PC_WIDTH-1:0] check_pc,
   input  logic                check_taken
);

   localparam int IDX_BITS = idx_bits(ENTRIES);
   localparam int TAG_BITS = tag_bits(PC_WIDTH, ENTRIES);

   typedef struct packed {
      logic                 valid;
      logic [TAG_BITS-1:0]  tag;
      logic [CTR_WIDTH-1:0] ctr;
   } entry_t;

   // ---------------------------------------------------------------------
   // Storage
   // ---------------------------------------------------------------------
   logic [ENTRIES-1:0]   valid_q;
   logic [TAG_BITS-1:0]  tag_q [ENTRIES];
   logic [CTR_WIDTH-1:0] ctr_q [ENTRIES];

   // ---------------------------------------------------------------------
   // Address decode
   // ---------------------------------------------------------------------
   logic [IDX_BITS-1:0] g_idx;
   logic [IDX_BITS-1:0] c_idx;
   logic [TAG_BITS-1:0] g_tag;
   logic [TAG_BITS-1:0] c_tag;

   assign g_idx = guess_pc[IDX_BITS+1:2];
   assign g_tag = guess_pc[PC_WIDTH-1:IDX_BITS+2];
   assign c_idx = check_pc[IDX_BITS+1:2];
   assign c_tag = check_pc[PC_WIDTH-1:IDX_BITS+2];

   // Byte-offset bits carry no information for the table.
   logic unused_pc_bits;
   assign unused_pc_bits = ^{guess_pc[1:0], check_pc[1:0]};

   // ---------------------------------------------------------------------
   // Update path
   // ---------------------------------------------------------------------
   entry_t               c_cur;
   logic                 c_hit;
   logic [CTR_WIDTH-1:0] c_ctr_next;

   assign c_cur = '{valid: valid_q[c_idx], tag: tag_q[c_idx], ctr: ctr_q[c_idx]};
   assign c_hit = c_cur.valid && (c_cur.tag == c_tag);

   bht_ctr_next #(
      .CTR_WIDTH (CTR_WIDTH)
   ) u_ctr_next (
      .hit      (c_hit),
      .ctr      (c_cur.ctr),
      .taken    (check_taken),
      .ctr_next (c_ctr_next)
   );

   // Valid bits are the only table state that reset must clear.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
         valid_q <= '0;
      end else if (check_valid) begin
         valid_q[c_idx] <= 1'b1;
      end
   end

   // A miss overwrites tag and counter together, evicting any alias.
   always_ff @(posedge clk) begin
      // NOTE: tag/ctr arrays are deliberately not reset; a cleared valid bit masks stale contents.
      if (check_valid) begin
         tag_q[c_idx] <= c_tag;
         ctr_q[c_idx] <= c_ctr_next;
      end
   end

   // ---------------------------------------------------------------------
   // Guess path
   // ---------------------------------------------------------------------
   entry_t g_cur;
   entry_t g_eff;
   logic   g_hit;
   logic   g_taken;

   assign g_cur = '{valid: valid_q[g_idx], tag: tag_q[g_idx], ctr: ctr_q[g_idx]};

`ifdef BHT_BYPASS_EN
   // Forward the entry as it will look after this edge's write.
   entry_t c_new;
   assign c_new = '{valid: 1'b1, tag: c_tag, ctr: c_ctr_next};

   always_comb begin
      g_eff = g_cur;
      if (check_valid && (c_idx == g_idx)) g_eff = c_new;
   end
`else
   // Read-before-write: the guess sees the table as it was before this edge.
   assign g_eff = g_cur;
`endif

   assign g_hit   = g_eff.valid && (g_eff.tag == g_tag);
   assign g_taken = g_hit && g_eff.ctr[CTR_WIDTH-1];

   // ---------------------------------------------------------------------
   // Output register: a single-cycle pulse per accepted guess; taken/hit are
   // held at zero whenever no guess was presented.
   // ---------------------------------------------------------------------
   bht_pred_t pred_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pred_q <= '0;
      end else begin
         pred_q.valid <= guess_valid;
         pred_q.hit   <= guess_valid && g_hit;
         pred_q.taken <= guess_valid && g_taken;
      end
   end

   assign pred_valid = pred_q.valid;
   assign pred_taken = pred_q.taken;
   assign pred_hit   = pred_q.hit;

endmodule
